seq_detect_ctrl: RTL and testbench

- Run-time programmable serial pattern detector with a configuration handshake, arm/disarm control, overlap mode and a saturating match counter.
- Sequences the single-bit detection path (serial input w, pulse output z) used by the FSM blocks.
- Lets the system load a new pattern and length without re-synthesis.
- Sits between a host/config master and a serial bitstream source.

---
 rtl/seq_detect_ctrl_if.sv | 48 ++++
 rtl/seq_detect_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl_if
//
// Configuration channel of the serial pattern detector.
//
// Handshake: a configuration transfer happens on every rising clock edge where
// cfg_valid and cfg_ready are both high. The master holds cfg_pattern, cfg_len
// and cfg_overlap stable while cfg_valid is high. cfg_valid seen while
// cfg_ready is low is ignored (no transfer, no error). cfg_err is a one-cycle
// pulse, in the cycle after a transfer whose cfg_len was outside 1..MAXLEN.
//
// Signals:
//   cfg_valid    master -> slave  configuration request
//   cfg_ready    slave  -> master slave can accept a configuration
//   cfg_pattern  master -> slave  pattern, bit[cfg_len-1] is the first bit seen
//   cfg_len      master -> slave  pattern length, legal 1..MAXLEN
//   cfg_overlap  master -> slave  1 = overlapping matches allowed
//   cfg_err      slave  -> master illegal-length rejection pulse
// -----------------------------------------------------------------------------
interface seq_detect_ctrl_if #(
    parameter int MAXLEN = 8,
    parameter int LENW   = $clog2(MAXLEN + 1)
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_len,
        output cfg_overlap,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_overlap,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Run-time programmable serial pattern detector. A host loads a pattern,
// its length and an overlap mode through the cfg interface, then arms the
// block. While armed, every w_valid cycle shifts w into a history register;
// when the newest cfg_len bits equal the pattern, z pulses one cycle later
// and a saturating match counter increments.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cfg          configuration channel (slave side, see seq_detect_ctrl_if)
//   arm          start detection (honoured only in CONFIGURED)
//   disarm       stop detection (honoured only in ARMED, wins over w_valid/arm)
//   w, w_valid   serial data bit and its qualifier
//   z            registered one-cycle match pulse
//   match_count  matches since last arm, saturating at all ones
//   armed        high while in ARMED
//   dbg_state    current FSM state encoding (IDLE=0, CONFIGURED=1, ARMED=2)
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_detect_ctrl_if.slave      cfg,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic                  w,
    input  logic                  w_valid,
    output logic                  z,
    output logic [CNTW-1:0]       match_count,
    output logic                  armed,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CONFIGURED = 2'd1,
        S_ARMED      = 2'd2
    } state_e;

    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e            state_q,   state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [LENW-1:0]   len_q,     len_d;
    logic              overlap_q, overlap_d;
    logic [MAXLEN-1:0] hist_q,    hist_d;
    logic [LENW-1:0]   fill_q,    fill_d;
    logic [CNTW-1:0]   count_q,   count_d;
    logic              z_q,       z_d;
    logic              err_q,     err_d;

    // ------------------------------------------------------------------
    // Helper combinational signals
    // ------------------------------------------------------------------
    logic              cfg_fire;
    logic              len_legal;
    logic [MAXLEN-1:0] hist_shift;
    logic [LENW-1:0]   fill_inc;
    logic [MAXLEN-1:0] len_mask;
    logic              hit;

    // Configuration is only accepted outside ARMED, so the pattern cannot
    // change underneath an active detection.
    assign cfg_fire  = cfg.cfg_valid && (state_q != S_ARMED);
    assign len_legal = (cfg.cfg_len != '0) && (cfg.cfg_len <= MAXLEN_L);

    // Newest sample enters at bit0; the oldest falls off the top.
    assign hist_shift = {hist_q[MAXLEN-2:0], w};
    assign fill_inc   = (fill_q == MAXLEN_L) ? fill_q : fill_q + LENW'(1);

    // Mask selecting the low len_q bits of the history. Built bitwise so a
    // full-length pattern (len_q == MAXLEN) needs no wider intermediate.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (LENW'(i) < len_q);
        end
    end

    // Hit is judged on the post-shift history and post-increment fill, so
    // the sample arriving this cycle takes part in the comparison.
    assign hit = (fill_inc >= len_q) &&
                 (((hist_shift ^ pattern_q) & len_mask) == '0);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        z_d       = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_fire) begin
                    if (len_legal) begin
                        pattern_d = cfg.cfg_pattern;
                        len_d     = cfg.cfg_len;
                        overlap_d = cfg.cfg_overlap;
                        state_d   = S_CONFIGURED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_CONFIGURED: begin
                if (cfg_fire) begin
                    if (len_legal) begin
                        pattern_d = cfg.cfg_pattern;
                        len_d     = cfg.cfg_len;
                        overlap_d = cfg.cfg_overlap;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A config loaded on this same edge is what ARMED will use,
                // since detection only ever reads the latched registers.
                if (arm) begin
                    state_d = S_ARMED;
                    hist_d  = '0;
                    fill_d  = '0;
                    count_d = '0;
                end
            end

            S_ARMED: begin
                if (disarm) begin
                    // Sample in this cycle is dropped; counter is left for
                    // the host to read until the next arm.
                    state_d = S_CONFIGURED;
                end else if (w_valid) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    if (hit) begin
                        z_d     = 1'b1;
                        count_d = (count_q == '1) ? count_q
                                                  : count_q + CNTW'(1);
                        // Non-overlap: demand a full fresh pattern next time.
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            z_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            z_q       <= z_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg.cfg_ready = (state_q != S_ARMED);
    assign cfg.cfg_err   = err_q;
    assign z             = z_q;
    assign match_count   = count_q;
    assign armed         = (state_q == S_ARMED);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 2;
    localparam int LENW   = 4;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_C = 2'd1;
    localparam logic [1:0] ST_A = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            arm, disarm, w, w_valid;
    logic            z, armed;
    logic [CNTW-1:0] match_count;
    logic [1:0]      dbg_state;

    seq_detect_ctrl_if #(.MAXLEN(MAXLEN)) cfg_if ();

    seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if.slave),
        .arm         (arm),
        .disarm      (disarm),
        .w           (w),
        .w_valid     (w_valid),
        .z           (z),
        .match_count (match_count),
        .armed       (armed),
        .dbg_state   (dbg_state)
    );

    // ---------------- vector records ----------------
    typedef struct {
        string      name;
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       arm;
        logic       dis;
        logic       w;
        logic       wv;
        logic       ez;
        logic [1:0] ecnt;
        logic       earm;
        logic       erdy;
        logic       eerr;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mkv(string name, logic cv, logic [7:0] pat, logic [3:0] len,
                                 logic ov, logic a, logic d, logic wi, logic wv,
                                 logic ez, logic [1:0] ecnt, logic earm, logic erdy,
                                 logic eerr, logic [1:0] est);
        vec_t v;
        v.name = name; v.cv = cv; v.pat = pat; v.len = len; v.ov = ov;
        v.arm = a; v.dis = d; v.w = wi; v.wv = wv;
        v.ez = ez; v.ecnt = ecnt; v.earm = earm; v.erdy = erdy; v.eerr = eerr; v.est = est;
        return v;
    endfunction

    task automatic add(vec_t v);
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(string name, string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", name, what, act, exp);
        end
    endtask

    task automatic check_outputs(vec_t v);
        check(v.name, "z",           32'(z),           32'(v.ez));
        check(v.name, "match_count", 32'(match_count), 32'(v.ecnt));
        check(v.name, "armed",       32'(armed),       32'(v.earm));
        check(v.name, "cfg_ready",   32'(cfg_if.cfg_ready), 32'(v.erdy));
        check(v.name, "cfg_err",     32'(cfg_if.cfg_err),   32'(v.eerr));
        check(v.name, "state",       32'(dbg_state),   32'(v.est));
    endtask

    // ---------------- driver ----------------
    task automatic drive(vec_t v);
        cfg_if.cfg_valid   = v.cv;
        cfg_if.cfg_pattern = v.pat;
        cfg_if.cfg_len     = v.len;
        cfg_if.cfg_overlap = v.ov;
        arm     = v.arm;
        disarm  = v.dis;
        w       = v.w;
        w_valid = v.wv;
    endtask

    // Apply one vector for one clock, then compare just after the edge.
    task automatic step(vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outputs(v);
    endtask

    function automatic vec_t idle_v(string name, logic ez, logic [1:0] ecnt, logic earm,
                                    logic erdy, logic [1:0] est);
        return mkv(name, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, ez, ecnt, earm, erdy, 0, est);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        //     name            cv pat    len   ov arm dis w  wv | z cnt arm rdy err st
        add(mkv("idle_len0",    1, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, ST_I));
        add(mkv("idle_arm_ign", 0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, ST_I));
        add(mkv("idle_hold",    0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, ST_I));
        add(mkv("cfg101_ov1",   1, 8'h05, 4'd3, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, ST_C));
        add(mkv("ov1_arm",      0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov1_s1",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov1_s2",       0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov1_s3",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("ov1_s4",       0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, ST_A));
        add(mkv("ov1_s5",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 2, 1, 0, 0, ST_A));
        add(mkv("ov1_quiet",    0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 2, 1, 0, 0, ST_A));
        add(mkv("ov1_disarm",   0, 8'h00, 4'd0, 0, 0, 1, 0, 0,  0, 2, 0, 1, 0, ST_C));
        add(mkv("cfg101_ov0",   1, 8'h05, 4'd3, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, ST_C));
        add(mkv("ov0_arm",      0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov0_s1",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov0_s2",       0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ov0_s3",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("ov0_s4",       0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, ST_A));
        add(mkv("ov0_s5",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, ST_A));
        add(mkv("ov0_disarm",   0, 8'h00, 4'd0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("conf_len9",    1, 8'h00, 4'd9, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, ST_C));
        add(mkv("conf_errdrop", 0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("old_arm",      0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("old_s1",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("old_s2_cfgign",1, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("old_s3",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("old_disarm",   0, 8'h00, 4'd0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("cfg11",        1, 8'h03, 4'd2, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("gap_arm",      0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("gap_s1",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("gap_hole1",    0, 8'h00, 4'd0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("gap_hole2",    0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("gap_s2",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("gap_after",    0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, ST_A));
        add(mkv("gap_disarm",   0, 8'h00, 4'd0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("cfg1",         1, 8'h01, 4'd1, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, ST_C));
        add(mkv("sat_arm",      0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("sat_1",        0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("sat_2",        0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 2, 1, 0, 0, ST_A));
        add(mkv("sat_3",        0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 3, 1, 0, 0, ST_A));
        add(mkv("sat_4",        0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 3, 1, 0, 0, ST_A));
        add(mkv("sat_5",        0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 3, 1, 0, 0, ST_A));
        add(mkv("sat_disarm_wv",0, 8'h00, 4'd0, 0, 0, 1, 1, 1,  0, 3, 0, 1, 0, ST_C));
        add(mkv("sat_hold",     0, 8'h00, 4'd0, 0, 0, 0, 0, 0,  0, 3, 0, 1, 0, ST_C));
        add(mkv("ad_arm",       0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("ad_both",      0, 8'h00, 4'd0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0, ST_C));
        add(mkv("cfgarm_same",  1, 8'h02, 4'd2, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        add(mkv("new_s1",       0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        add(mkv("new_s2",       0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, ST_A));
        add(mkv("new_disarm",   0, 8'h00, 4'd0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, ST_C));

        // reset phase
        reset = 1'b0;
        drive(idle_v("init", 0, 0, 0, 1, ST_I));
        repeat (3) @(posedge clk);
        #1;
        check_outputs(idle_v("reset", 0, 0, 0, 1, ST_I));
        reset = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset while armed with match_count=2 and z high.
        step(mkv("r_cfg",  1, 8'h05, 4'd3, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, ST_C));
        step(mkv("r_arm",  0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));
        step(mkv("r_s1",   0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, ST_A));
        step(mkv("r_s2",   0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, ST_A));
        step(mkv("r_s3",   0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, ST_A));
        step(mkv("r_s4",   0, 8'h00, 4'd0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, ST_A));
        step(mkv("r_s5",   0, 8'h00, 4'd0, 0, 0, 0, 1, 1,  1, 2, 1, 0, 0, ST_A));
        drive(idle_v("r_idle", 0, 2, 1, 0, ST_A));
        #1;
        reset = 1'b0;
        #1;
        check_outputs(idle_v("r_async", 0, 0, 0, 1, ST_I));
        @(posedge clk);
        #1;
        check_outputs(idle_v("r_held", 0, 0, 0, 1, ST_I));
        reset = 1'b1;
        step(mkv("r_arm_only", 0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, ST_I));
        step(mkv("r_recfg",    1, 8'h05, 4'd3, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, ST_C));
        step(mkv("r_rearm",    0, 8'h00, 4'd0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, ST_A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
